// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback stage:
// condition codes, FSM state encoding and NZCV bit positions.
package alu_writeback_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB_LO = 2'd1,
    WB_HI = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_writeback_cond_check.sv
// Combinational ARM condition evaluator:
// Cond field against NZCV flags.
module cond_check
  import alu_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cx
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field; 1111 behaves like AL
  always_comb begin
    cx = 1'b1;
    unique case (cond)
      COND_EQ: cx = z;
      COND_NE: cx = !z;
      COND_CS: cx = c;
      COND_CC: cx = !c;
      COND_MI: cx = n;
      COND_PL: cx = !n;
      COND_VS: cx = v;
      COND_VC: cx = !v;
      COND_HI: cx = c & !z;
      COND_LS: cx = !c | z;
      COND_GE: cx = (n == v);
      COND_LT: cx = (n != v);
      COND_GT: cx = !z & (n == v);
      COND_LE: cx = z | (n != v);
      COND_AL: cx = 1'b1;
      default: cx = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures ALU results, owns NZCV,
// and sequences one or two register-file writes.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] ResultHi,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             RegW,
  input  logic             is_long,
  input  logic [RA_W-1:0]  RdLo,
  input  logic [RA_W-1:0]  RdHi,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             RegWrite,
  output logic [RA_W-1:0]  WA3,
  output logic [WIDTH-1:0] WD3,
  output logic             busy,
  output logic             done
);

  wb_state_t        state;
  logic [RA_W-1:0]  rd_hi_q;
  logic             long_q;
  logic             cx;
  logic [3:0]       flags_nxt;

  cond_check u_cond (
    .cond  (Cond),
    .flags (Flags),
    .cx    (cx)
  );

  // Flags after a passing instruction, per FlagW field
  always_comb begin
    flags_nxt = Flags;
    if (cx && FlagW[1])
      flags_nxt[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (cx && FlagW[0])
      flags_nxt[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
  end

  // FSM with registered write-port and status outputs;
  // WA3 doubles as the latched RdLo for the first write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ALUOut   <= '0;
      ALUOutHi <= '0;
      Flags    <= '0;
      CondEx   <= 1'b0;
      rd_hi_q  <= '0;
      long_q   <= 1'b0;
      RegWrite <= 1'b0;
      WA3      <= '0;
      WD3      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      WA3      <= '0;
      WD3      <= '0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            ALUOut   <= Result;
            ALUOutHi <= ResultHi;
            rd_hi_q  <= RdHi;
            long_q   <= is_long;
            CondEx   <= cx;
            Flags    <= flags_nxt;
            busy     <= 1'b1;
            if (RegW && cx) begin
              state    <= WB_LO;
              RegWrite <= 1'b1;
              WA3      <= RdLo;
              WD3      <= Result;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        WB_LO: begin
          if (long_q) begin
            state    <= WB_HI;
            RegWrite <= 1'b1;
            WA3      <= rd_hi_q;
            WD3      <= ALUOutHi;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        WB_HI: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed
// scenarios plus random ops against a reference model.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture;
  logic [31:0] Result, ResultHi;
  logic [3:0]  ALUFlags, Cond;
  logic [1:0]  FlagW;
  logic        RegW, is_long;
  logic [3:0]  RdLo, RdHi;
  logic [31:0] ALUOut, ALUOutHi, WD3;
  logic [3:0]  Flags, WA3;
  logic        CondEx, RegWrite, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  m_flags;
  logic [31:0] m_out, m_outhi;
  logic        m_cx;

  alu_writeback #(.WIDTH(32), .RA_W(4)) dut (
    .clk(clk), .reset(reset), .capture(capture),
    .Result(Result), .ResultHi(ResultHi),
    .ALUFlags(ALUFlags), .Cond(Cond), .FlagW(FlagW),
    .RegW(RegW), .is_long(is_long),
    .RdLo(RdLo), .RdHi(RdHi),
    .ALUOut(ALUOut), .ALUOutHi(ALUOutHi),
    .Flags(Flags), .CondEx(CondEx),
    .RegWrite(RegWrite), .WA3(WA3), .WD3(WD3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ARM rule: pairs of codes share a base test, odd code
  // of a pair is its negation, code pair 7 is always true
  function automatic logic cond_ref(input logic [3:0] cd,
                                    input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (cd[0] && cd[3:1] != 3'd7) ? !base : base;
  endfunction

  task automatic model_reset;
    m_flags = 4'h0;
    m_out   = 32'h0;
    m_outhi = 32'h0;
    m_cx    = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] cd,
                        input logic [1:0] fw,
                        input logic rw, input logic lg,
                        input logic [31:0] r,
                        input logic [31:0] rh,
                        input logic [3:0] af,
                        input logic [3:0] rl,
                        input logic [3:0] rhd,
                        input bit poke_busy,
                        input bit poke_done);
    int nw;
    Cond = cd; FlagW = fw; RegW = rw; is_long = lg;
    Result = r; ResultHi = rh; ALUFlags = af;
    RdLo = rl; RdHi = rhd; capture = 1'b1;
    m_cx = cond_ref(cd, m_flags);
    if (m_cx && fw[1]) m_flags[3:2] = af[3:2];
    if (m_cx && fw[0]) m_flags[1:0] = af[1:0];
    m_out = r; m_outhi = rh;
    nw = (rw && m_cx) ? (lg ? 2 : 1) : 0;
    tick;
    capture = 1'b0;
    check("condex", 32'(CondEx), 32'(m_cx));
    check("flags", 32'(Flags), 32'(m_flags));
    check("aluout", ALUOut, m_out);
    check("aluouthi", ALUOutHi, m_outhi);
    for (int i = 0; i < nw; i++) begin
      check("regwrite", 32'(RegWrite), 32'd1);
      check("wa3", 32'(WA3), 32'(i == 0 ? rl : rhd));
      check("wd3", WD3, i == 0 ? r : rh);
      check("busy_wb", 32'(busy), 32'd1);
      check("done_wb", 32'(done), 32'd0);
      if (poke_busy && i == 0) begin
        capture = 1'b1; Result = ~r; ResultHi = ~rh;
        ALUFlags = ~af; Cond = COND_AL; FlagW = 2'b11;
        RegW = 1'b1;
      end
      tick;
      capture = 1'b0;
    end
    check("done", 32'(done), 32'd1);
    check("regwrite_done", 32'(RegWrite), 32'd0);
    check("busy_done", 32'(busy), 32'd1);
    check("wa3_idle", 32'(WA3), 32'd0);
    check("wd3_idle", WD3, 32'd0);
    if (poke_done) begin
      capture = 1'b1; Result = ~r; ResultHi = ~rh;
      ALUFlags = ~af; Cond = COND_AL; FlagW = 2'b11;
      RegW = 1'b1;
    end
    tick;
    capture = 1'b0;
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("regwrite_idle", 32'(RegWrite), 32'd0);
    check("aluout_hold", ALUOut, m_out);
    check("aluouthi_hold", ALUOutHi, m_outhi);
    check("flags_hold", 32'(Flags), 32'(m_flags));
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0;
    Result = '0; ResultHi = '0; ALUFlags = '0;
    Cond = '0; FlagW = '0; RegW = 1'b0; is_long = 1'b0;
    RdLo = '0; RdHi = '0;
    model_reset();

    // Reset held: everything zero, capture ignored
    #2;
    capture = 1'b1; Result = 32'hDEAD_BEEF;
    Cond = COND_AL; FlagW = 2'b11; ALUFlags = 4'hF;
    RegW = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      check("rst_aluout", ALUOut, 32'h0);
      check("rst_flags", 32'(Flags), 32'h0);
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_condex", 32'(CondEx), 32'd0);
    end

    // Release with capture in the same cycle
    reset = 1'b0;
    run_op(COND_AL, 2'b11, 1'b1, 1'b0, 32'h0, 32'h0,
           4'b0100, 4'd3, 4'd0, 1'b0, 1'b0);

    // NE with Z set: fails, flags untouched
    run_op(COND_NE, 2'b11, 1'b1, 1'b0, 32'h1234_5678,
           32'h0, 4'b1000, 4'd2, 4'd0, 1'b0, 1'b0);

    // Long op with a capture poked while busy
    run_op(COND_AL, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 4'h0, 4'd4, 4'd5, 1'b1, 1'b1);

    // Set flags to C only, then HI with FlagW=10
    run_op(COND_AL, 2'b11, 1'b0, 1'b0, 32'h5, 32'h6,
           4'b0010, 4'd1, 4'd1, 1'b0, 1'b0);
    run_op(COND_HI, 2'b10, 1'b0, 1'b0, 32'h7, 32'h8,
           4'b1101, 4'd1, 4'd1, 1'b0, 1'b0);
    check("hi_flags", 32'(Flags), 32'h0000_000E);

    // Long op with RdLo == RdHi
    run_op(COND_AL, 2'b00, 1'b1, 1'b1, 32'hAAAA_0001,
           32'h5555_0002, 4'h0, 4'd7, 4'd7, 1'b0, 1'b0);

    // Reset during WB_LO of a long op
    Cond = COND_AL; FlagW = 2'b11; RegW = 1'b1;
    is_long = 1'b1; Result = 32'h1111_2222;
    ResultHi = 32'h3333_4444; ALUFlags = 4'b1001;
    RdLo = 4'd8; RdHi = 4'd9; capture = 1'b1;
    tick;
    capture = 1'b0;
    check("mid_regwrite", 32'(RegWrite), 32'd1);
    check("mid_wa3", 32'(WA3), 32'd8);
    #1 reset = 1'b1;
    #1;
    check("arst_regwrite", 32'(RegWrite), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_flags", 32'(Flags), 32'h0);
    check("arst_aluout", ALUOut, 32'h0);
    tick;
    check("arst_no_hi", 32'(RegWrite), 32'd0);
    check("arst_wa3", 32'(WA3), 32'd0);
    reset = 1'b0;
    model_reset();
    tick;
    check("post_rst_regwrite", 32'(RegWrite), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Random ops against the model
    for (int t = 0; t < 60; t++) begin
      run_op(4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom, $urandom,
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
